// File: rtl/act_pipe.sv
// act_pipe: two-stage pipelined activation unit for LANES signed accumulator
// values per beat.
//
// The mode is carried with each beat:
//   00 sigmoid (piecewise linear)
//   01 ReLU
//   10 hard-tanh with a +128 offset
//   11 reserved (outputs zero and sets err_sticky)
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is combinational
//   in_data               lane i at [i*IN_W +: IN_W], two's complement
//   in_mode               per-beat activation mode
//   out_valid/out_ready   output handshake with full backpressure
//   out_data              lane i at [i*8 +: 8], unsigned
//   sat_cnt               saturating count of output lanes equal to 0 or 255
//   cnt_clr               synchronous clear of sat_cnt
//   err_sticky            set when a reserved-mode beat is accepted
module act_pipe #(
  parameter int IN_W  = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*IN_W-1:0]   in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*8-1:0]      out_data,
  output logic [CNT_W-1:0]        sat_cnt,
  input  logic                    cnt_clr,
  output logic                    err_sticky
);

  // Two extra bits hold x+128 and 1.5*x without overflow.
  localparam int EW = IN_W + 2;
  localparam int NW = $clog2(LANES + 1);

  localparam logic [1:0] MODE_SIG   = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_HTANH = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [2:0] SEG_LOW  = 3'd0;
  localparam logic [2:0] SEG_RISE = 3'd1;
  localparam logic [2:0] SEG_MID  = 3'd2;
  localparam logic [2:0] SEG_KNEE = 3'd3;
  localparam logic [2:0] SEG_HIGH = 3'd4;

  localparam logic signed [IN_W-1:0] X_M128 = IN_W'(-128);
  localparam logic signed [IN_W-1:0] X_M64  = IN_W'(-64);
  localparam logic signed [IN_W-1:0] X_64   = IN_W'(64);
  localparam logic signed [IN_W-1:0] X_126  = IN_W'(126);

  localparam logic signed [EW-1:0] E_0   = EW'(0);
  localparam logic signed [EW-1:0] E_64  = EW'(64);
  localparam logic signed [EW-1:0] E_128 = EW'(128);
  localparam logic signed [EW-1:0] E_224 = EW'(224);
  localparam logic signed [EW-1:0] E_255 = EW'(255);

  function automatic logic [2:0] seg_decode(input logic signed [IN_W-1:0] x);
    if (x <= X_M128)    return SEG_LOW;
    else if (x < X_M64) return SEG_RISE;
    else if (x < X_64)  return SEG_MID;
    else if (x < X_126) return SEG_KNEE;
    else                return SEG_HIGH;
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [EW-1:0] v);
    if (v < E_0)        return 8'd0;
    else if (v > E_255) return 8'hFF;
    else                return v[7:0];
  endfunction

  function automatic logic [7:0] act_lane(input logic signed [IN_W-1:0] x,
                                          input logic [1:0]             mode,
                                          input logic [2:0]             seg);
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] v;
    xe = EW'(x);
    v  = E_0;
    case (mode)
      MODE_SIG: begin
        case (seg)
          SEG_LOW:  v = E_0;
          SEG_RISE: v = (xe + E_128) >>> 1;
          SEG_MID:  v = E_128 + xe + (xe >>> 1);
          SEG_KNEE: v = E_224 + ((xe - E_64) >>> 1);
          default:  v = E_255;
        endcase
      end
      MODE_RELU:  v = xe;
      MODE_HTANH: v = xe + E_128;
      default:    v = E_0;
    endcase
    return sat_u8(v);
  endfunction

  logic                   vld_p1;
  logic [1:0]             mode_p1;
  logic signed [IN_W-1:0] x_p1   [LANES];
  logic [2:0]             seg_p1 [LANES];

  logic                   vld_p2;
  logic [LANES*8-1:0]     y_p2;

  logic                   adv1;
  logic                   adv2;
  logic                   out_hs;
  logic [LANES*8-1:0]     y_next;
  logic [NW-1:0]          sat_lanes;
  logic [CNT_W:0]         cnt_sum;

  assign adv2      = !vld_p2 || out_ready;
  assign adv1      = !vld_p1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p2;
  assign out_data  = y_p2;
  assign out_hs    = vld_p2 && out_ready;

  // ---- Stage 1: capture lanes and mode, decode sigmoid segment ----
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      mode_p1 <= in_mode;
      for (int i = 0; i < LANES; i++) begin
        x_p1[i]   <= in_data[i*IN_W +: IN_W];
        seg_p1[i] <= seg_decode(in_data[i*IN_W +: IN_W]);
      end
    end
  end

  always_comb begin
    y_next = '0;
    for (int i = 0; i < LANES; i++) begin
      y_next[i*8 +: 8] = act_lane(x_p1[i], mode_p1, seg_p1[i]);
    end
  end

  // ---- Stage 2: registered activation result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      y_p2       <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) y_p2 <= y_next;
      end
      if (in_valid && adv1 && (in_mode == MODE_RSVD)) err_sticky <= 1'b1;
    end
  end

  // ---- Output side: saturation statistics on each output handshake ----
  always_comb begin
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((y_p2[i*8 +: 8] == 8'd0) || (y_p2[i*8 +: 8] == 8'hFF)) begin
        sat_lanes = sat_lanes + NW'(1);
      end
    end
  end

  assign cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(sat_lanes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_hs) begin
      sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Testbench for act_pipe.
// A scoreboard queue is filled at every input handshake with the expected
// beat, taken either from a plain-arithmetic reference model or from a
// directed constant. A negedge monitor pops and compares at each output
// handshake, checks that a stalled output holds its value, and tracks
// sat_cnt against a model count.
module tb_act_pipe;
  localparam int IN_W  = 32;
  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_data = '0;
  logic [1:0]            in_mode = 2'd0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [LANES*8-1:0]    out_data;
  logic [CNT_W-1:0]      sat_cnt;
  logic                  cnt_clr = 1'b0;
  logic                  err_sticky;

  act_pipe #(.IN_W(IN_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_cnt(sat_cnt),
    .cnt_clr(cnt_clr), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          model_cnt = 0;
  bit          mon_en = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  bit          m_hs;
  int          m_n;
  logic [31:0] m_e;
  bit          stop_rand;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor of v/2 written with integer division.
  function automatic longint fl2(input longint v);
    if (v >= 0) return v / 2;
    else        return -((1 - v) / 2);
  endfunction

  function automatic int ref_y(input longint x, input int mode);
    longint v;
    case (mode)
      0: begin
        if (x <= -128)     v = 0;
        else if (x < -64)  v = fl2(x + 128);
        else if (x < 64)   v = 128 + x + fl2(x);
        else if (x < 126)  v = 224 + fl2(x - 64);
        else               v = 255;
      end
      1:       v = x;
      2:       v = x + 128;
      default: v = 0;
    endcase
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return int'(v);
  endfunction

  function automatic logic [31:0] model_beat(input logic [127:0] d, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*8 +: 8] = 8'(ref_y(longint'($signed(d[i*32 +: 32])), int'(m)));
    return r;
  endfunction

  function automatic logic [127:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [31:0] pack8(input int b0, input int b1, input int b2, input int b3);
    return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  function automatic int rnd_x();
    int bp[8];
    bp = '{-128, -64, 0, 64, 126, 255, -129, 127};
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom());
      default: return bp[$urandom_range(0, 7)] + int'($urandom_range(0, 2)) - 1;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [127:0] d, input logic [1:0] m,
                      input bit ovr, input logic [31:0] exp);
    int w;
    bit done;
    w = 0;
    done = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ovr ? exp : model_beat(d, m));
        done = 1;
      end else begin
        w++;
        if (w > 200) begin
          check("in_ready_wait", in_ready, 1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Output monitor and sat_cnt model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sat_cnt", sat_cnt, model_cnt);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      m_hs = out_valid && out_ready;
      m_n  = 0;
      if (m_hs) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", out_data, 'x);
        end else begin
          m_e = exp_q.pop_front();
          check("out_data", out_data, m_e);
          for (int i = 0; i < LANES; i++)
            if (m_e[i*8 +: 8] == 8'd0 || m_e[i*8 +: 8] == 8'd255) m_n++;
        end
      end
      if (cnt_clr)   model_cnt = 0;
      else if (m_hs) model_cnt = (model_cnt + m_n > CNT_MAX) ? CNT_MAX : model_cnt + m_n;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_err", err_sticky, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    mon_en = 1;

    // Basic sigmoid beat with latency and counter check
    send(pack4(-200, -100, 0, 100), 2'd0, 1, pack8(0, 14, 128, 242));
    check("lat_cycle1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_cycle2", out_valid, 1);
    check("t1_data", out_data, pack8(0, 14, 128, 242));
    @(posedge clk); #1;
    check("t1_sat", sat_cnt, 1);

    // Breakpoint sweep, back to back with mixed modes
    send(pack4(-128, -127, -64, -1), 2'd0, 1, pack8(0, 0, 32, 126));
    send(pack4(63, 64, 125, 126),    2'd0, 1, pack8(222, 224, 254, 255));
    send(pack4(-1, 255, 256, 0),     2'd1, 1, pack8(0, 255, 255, 0));
    send(pack4(-129, 127, 0, -128),  2'd2, 1, pack8(0, 255, 128, 0));
    drain();

    // Backpressure: two beats fill the pipe, then three more wait
    out_ready = 1'b0;
    send(pack4(1, 2, 3, 4), 2'd0, 0, '0);
    send(pack4(-70, 70, 300, -300), 2'd1, 0, '0);
    check("bp_in_ready_low", in_ready, 0);
    fork
      begin
        send(pack4(10, 20, 30, 40), 2'd2, 0, '0);
        send(pack4(-5, 5, -150, 150), 2'd0, 0, '0);
        send(pack4(99, -99, 200, -200), 2'd1, 0, '0);
      end
      begin
        repeat (4) begin @(posedge clk); #1; check("bp_stall_ready", in_ready, 0); end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reserved mode then normal sigmoid
    check("err_before", err_sticky, 0);
    send(pack4(5, -5, 1000, -1000), 2'd3, 1, pack8(0, 0, 0, 0));
    check("err_set", err_sticky, 1);
    send(pack4(10, -10, 70, -70), 2'd0, 0, '0);
    drain();
    check("err_stays", err_sticky, 1);

    // Randomized beats with random backpressure and gaps
    stop_rand = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send(pack4(rnd_x(), rnd_x(), rnd_x(), rnd_x()), 2'($urandom_range(0, 3)), 0, '0);
        end
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter saturation with 2^CNT_W fully saturated beats
    for (int n = 0; n < (1 << CNT_W); n++)
      send(pack4(500, -500, 1000, -1000), 2'd0, 0, '0);
    drain();
    check("cnt_saturated", sat_cnt, CNT_MAX);

    // cnt_clr in the same cycle as an output handshake
    send(pack4(500, -500, 1000, -1000), 2'd0, 0, '0);
    @(posedge clk); #1;
    check("clr_out_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_sat_zero", sat_cnt, 0);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(pack4(1, 2, 3, 4), 2'd0, 0, '0);
    send(pack4(5, 6, 7, 8), 2'd1, 0, '0);
    mon_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat", sat_cnt, 0);
    check("mid_rst_err", err_sticky, 0);
    check("mid_rst_data", out_data, 0);
    exp_q.delete();
    model_cnt = 0;
    prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    mon_en = 1;
    repeat (5) begin @(posedge clk); #1; check("post_rst_no_beat", out_valid, 0); end
    send(pack4(-100, 100, 0, 300), 2'd2, 0, '0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_pipe.md
Name: act_pipe

Overview:
- Parametrised, pipelined successor to the combinational sigmoid activation. Processes LANES signed accumulator values per beat.
- Each beat carries a per-beat activation mode: sigmoid PWL, ReLU, hard-tanh (offset) or reserved.
- Valid/ready handshake on both sides with full backpressure.
- Sits between the MAC array output and the activation buffer. Keeps a saturation-statistics counter and a sticky error flag for the host.

Parameters:
- IN_W, 32, signed input width per lane; legal range 10..32.
- LANES, 4, lanes per beat.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], two's complement.
- in_mode  in  2  00 sigmoid, 01 relu, 10 htanh, 11 reserved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*8  lane i at bits [i*8 +: 8], unsigned.
- sat_cnt  out  CNT_W  count of saturated lanes.
- cnt_clr  in  1  synchronous clear of sat_cnt.
- err_sticky  out  1  set when a reserved mode is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valids cleared; out_valid=0.
  - out_data=0, sat_cnt=0, err_sticky=0.
  - in_ready=1 after reset deasserts.
- Pipeline: 2 register stages (S1 captures data and mode and decodes segment; S2 holds the result). Latency is 2 cycles from input handshake to out_valid with no stall.
- Stall rules:
  - S2 advances when !s2_valid or out_ready.
  - S1 advances when !s1_valid or S2 advances.
  - in_ready = S1 advances (combinational). Throughput is 1 beat/cycle.
- Handshake:
  - A beat is transferred when valid and ready are both high.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - No beat is dropped or duplicated.
- Sigmoid (00), per lane, x signed. Shifts are arithmetic (floor); results clamp to 0..255.
  - x <= -128: y=0.
  - -128 < x < -64: y = (x+128)>>>1.
  - -64 <= x < 64: y = 128 + x + (x>>>1).
  - 64 <= x < 126: y = 224 + ((x-64)>>>1).
  - x >= 126: y=255.
  - The curve is continuous at breakpoints: y(-64)=32, y(0)=128, y(64)=224.
- ReLU (01): y = 0 if x<0; 255 if x>255; else x[7:0].
- Htanh (10): y = clamp(x+128, 0, 255). x+128 is computed at IN_W+1 bits, so no overflow.
- Reserved (11):
  - All lanes output 0 and the beat still flows through.
  - err_sticky is set at the input handshake. It is cleared only by reset.
- Saturation counter:
  - On each output handshake, sat_cnt += number of lanes with y==0 or y==255, in every mode.
  - sat_cnt sticks at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets sat_cnt to 0 next edge. If an output handshake occurs the same cycle, that cycle's increment is discarded.
- Mode is per beat: consecutive beats with different modes are processed independently, with no bubble.
- Reset mid-operation: in-flight beats are discarded. No partial output is presented after rst_n deasserts.

Test Plan:
- Sigmoid, LANES=4, in lanes {-200, -100, 0, 100}, out_ready=1:
  - Required out lanes {0, 14, 128, 242}, 2 cycles after handshake.
  - sat_cnt increments by 1.
- Breakpoint sweep, sigmoid, x in {-128, -127, -64, -1, 63, 64, 125, 126}:
  - Required y = {0, 0, 32, 126, 222, 224, 254, 255}.
  - Also cover relu with x in {-1, 255, 256} -> {0, 255, 255}, and htanh with x in {-129, 127} -> {0, 255}.
- Backpressure: 5 back-to-back beats with out_ready low for cycles 2-6:
  - in_ready drops after 2 beats are buffered.
  - Output holds stable while stalled.
  - All 5 beats emerge in order, with no loss or duplication.
- Reserved mode:
  - Beat with in_mode=11 -> all lanes 0, err_sticky=1 from the next cycle.
  - A subsequent sigmoid beat is computed normally and err_sticky stays 1.
- Counter:
  - Drive 2^CNT_W beats of 4 saturated lanes -> sat_cnt holds at all-ones.
  - cnt_clr asserted during an output handshake -> sat_cnt=0 next cycle.
- Reset mid-stream: drop rst_n with 2 beats in flight -> out_valid=0 immediately, sat_cnt=0, and no stale beat appears after release.
